// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit -- control FSM for the RISC-SPM datapath.
//
// Sequences fetch, decode and execute of the 8-bit instruction set and drives
// every register load strobe and bus mux select of the datapath.
// Instruction layout: opcode = instruction[7:4], src = [3:2], dest = [1:0].
//
// Ports:
//   clk            clock, state advances on posedge
//   rst            asynchronous, active-low reset (state -> S_IDLE)
//   instruction    current IR contents
//   zero           registered ALU zero flag (Reg_Z output)
//   load_R0..R3    general-purpose register load strobes (indexed by dest)
//   load_PC        PC load from Bus_2
//   inc_PC         PC increment
//   load_IR        IR load from Bus_2
//   load_Add_R     address register load from Bus_2
//   load_Reg_Y     ALU operand Y load from Bus_2
//   load_Reg_Z     zero-flag register load
//   sel_bus_1_mux  0=R0 1=R1 2=R2 3=R3 4=PC
//   sel_bus_2_mux  0=ALU 1=Bus_1 2=memory
//   write          memory write strobe
//   halted         high while in S_HALT
//   state_dbg      current state register, for observation only
//
// Build option: define RISC_ILLEGAL_NOP_EN to treat opcodes 9-15 as NOP
// instead of halting. In that build S_HALT is unreachable and halted stays 0.
//
// Outputs are purely combinational from state, opcode, src, dest and zero.
// Every output defaults to 0 (selects included) and is forced to 0 while
// rst is low, so an aborted instruction cannot complete a partial write.
// ---------------------------------------------------------------------------
module control_unit #(
  parameter int word_size  = 8,
  parameter int op_size    = 4,
  parameter int state_size = 4,
  parameter int sel1_size  = 3,
  parameter int sel2_size  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_size-1:0]  instruction,
  input  logic                  zero,
  output logic                  load_R0,
  output logic                  load_R1,
  output logic                  load_R2,
  output logic                  load_R3,
  output logic                  load_PC,
  output logic                  inc_PC,
  output logic                  load_IR,
  output logic                  load_Add_R,
  output logic                  load_Reg_Y,
  output logic                  load_Reg_Z,
  output logic [sel1_size-1:0]  sel_bus_1_mux,
  output logic [sel2_size-1:0]  sel_bus_2_mux,
  output logic                  write,
  output logic                  halted,
  output logic [state_size-1:0] state_dbg
);

  localparam logic [state_size-1:0] S_IDLE = 4'd0;
  localparam logic [state_size-1:0] S_FET1 = 4'd1;
  localparam logic [state_size-1:0] S_FET2 = 4'd2;
  localparam logic [state_size-1:0] S_DEC  = 4'd3;
  localparam logic [state_size-1:0] S_EX1  = 4'd4;
  localparam logic [state_size-1:0] S_RD1  = 4'd5;
  localparam logic [state_size-1:0] S_RD2  = 4'd6;
  localparam logic [state_size-1:0] S_WR1  = 4'd7;
  localparam logic [state_size-1:0] S_WR2  = 4'd8;
  localparam logic [state_size-1:0] S_BR1  = 4'd9;
  localparam logic [state_size-1:0] S_BR2  = 4'd10;
  localparam logic [state_size-1:0] S_HALT = 4'd11;

  localparam logic [op_size-1:0] OP_NOP = 4'd0;
  localparam logic [op_size-1:0] OP_ADD = 4'd1;
  localparam logic [op_size-1:0] OP_SUB = 4'd2;
  localparam logic [op_size-1:0] OP_AND = 4'd3;
  localparam logic [op_size-1:0] OP_NOT = 4'd4;
  localparam logic [op_size-1:0] OP_RD  = 4'd5;
  localparam logic [op_size-1:0] OP_WR  = 4'd6;
  localparam logic [op_size-1:0] OP_BR  = 4'd7;
  localparam logic [op_size-1:0] OP_BRZ = 4'd8;

  localparam logic [sel1_size-1:0] SEL1_PC  = 3'd4;
  localparam logic [sel2_size-1:0] SEL2_ALU = 2'd0;
  localparam logic [sel2_size-1:0] SEL2_B1  = 2'd1;
  localparam logic [sel2_size-1:0] SEL2_MEM = 2'd2;

  logic [state_size-1:0] state_q, state_d;
  logic [op_size-1:0]    opcode;
  logic [1:0]            src;
  logic [1:0]            dest;
  logic [3:0]            load_r;

  assign opcode = instruction[word_size-1:word_size-op_size];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  assign load_R0   = load_r[0];
  assign load_R1   = load_r[1];
  assign load_R2   = load_r[2];
  assign load_R3   = load_r[3];
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = S_IDLE;
    load_r        = 4'b0000;
    load_PC       = 1'b0;
    inc_PC        = 1'b0;
    load_IR       = 1'b0;
    load_Add_R    = 1'b0;
    load_Reg_Y    = 1'b0;
    load_Reg_Z    = 1'b0;
    sel_bus_1_mux = '0;
    sel_bus_2_mux = '0;
    write         = 1'b0;
    halted        = 1'b0;
    // Gating on rst keeps the outputs at 0 for the whole reset interval, not
    // just after the state flop has been cleared.
    if (rst) begin
      case (state_q)
        S_IDLE: state_d = S_FET1;
        S_FET1: begin
          sel_bus_1_mux = SEL1_PC;
          sel_bus_2_mux = SEL2_B1;
          load_Add_R    = 1'b1;
          state_d       = S_FET2;
        end
        S_FET2: begin
          sel_bus_2_mux = SEL2_MEM;
          load_IR       = 1'b1;
          inc_PC        = 1'b1;
          state_d       = S_DEC;
        end
        S_DEC: begin
          case (opcode)
            OP_NOP: state_d = S_FET1;
            OP_ADD, OP_SUB, OP_AND: begin
              sel_bus_1_mux = {1'b0, src};
              sel_bus_2_mux = SEL2_B1;
              load_Reg_Y    = 1'b1;
              state_d       = S_EX1;
            end
            OP_NOT: begin
              sel_bus_1_mux = {1'b0, src};
              sel_bus_2_mux = SEL2_ALU;
              load_r[dest]  = 1'b1;
              load_Reg_Z    = 1'b1;
              state_d       = S_FET1;
            end
            OP_RD, OP_WR, OP_BR: begin
              sel_bus_1_mux = SEL1_PC;
              sel_bus_2_mux = SEL2_B1;
              load_Add_R    = 1'b1;
              if (opcode == OP_RD)      state_d = S_RD1;
              else if (opcode == OP_WR) state_d = S_WR1;
              else                      state_d = S_BR1;
            end
            OP_BRZ: begin
              if (zero) begin
                sel_bus_1_mux = SEL1_PC;
                sel_bus_2_mux = SEL2_B1;
                load_Add_R    = 1'b1;
                state_d       = S_BR1;
              end else begin
                // Branch not taken: step the PC over the address byte.
                inc_PC  = 1'b1;
                state_d = S_FET1;
              end
            end
            default: begin
`ifdef RISC_ILLEGAL_NOP_EN
              state_d = S_FET1;
`else
              state_d = S_HALT;
`endif
            end
          endcase
        end
        S_EX1: begin
          sel_bus_1_mux = {1'b0, dest};
          sel_bus_2_mux = SEL2_ALU;
          load_r[dest]  = 1'b1;
          load_Reg_Z    = 1'b1;
          state_d       = S_FET1;
        end
        S_RD1: begin
          sel_bus_2_mux = SEL2_MEM;
          load_Add_R    = 1'b1;
          inc_PC        = 1'b1;
          state_d       = S_RD2;
        end
        S_RD2: begin
          sel_bus_2_mux = SEL2_MEM;
          load_r[dest]  = 1'b1;
          state_d       = S_FET1;
        end
        S_WR1: begin
          sel_bus_2_mux = SEL2_MEM;
          load_Add_R    = 1'b1;
          inc_PC        = 1'b1;
          state_d       = S_WR2;
        end
        S_WR2: begin
          sel_bus_1_mux = {1'b0, src};
          write         = 1'b1;
          state_d       = S_FET1;
        end
        S_BR1: begin
          sel_bus_2_mux = SEL2_MEM;
          load_Add_R    = 1'b1;
          state_d       = S_BR2;
        end
        S_BR2: begin
          sel_bus_2_mux = SEL2_MEM;
          load_PC       = 1'b1;
          state_d       = S_FET1;
        end
        S_HALT: begin
          halted  = 1'b1;
          state_d = S_HALT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit -- directed bench for control_unit.
// Inputs change 2 time units after each rising edge; outputs are checked
// after a further 1 unit settle, well away from the active edge.
// Observed outputs are packed as:
//   {load_R3,load_R2,load_R1,load_R0, load_PC,inc_PC,load_IR,load_Add_R,
//    load_Reg_Y,load_Reg_Z, sel_bus_1_mux[2:0], sel_bus_2_mux[1:0],
//    write, halted}
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       zero;
  logic       load_R0, load_R1, load_R2, load_R3;
  logic       load_PC, inc_PC, load_IR, load_Add_R, load_Reg_Y, load_Reg_Z;
  logic [2:0] sel_bus_1_mux;
  logic [1:0] sel_bus_2_mux;
  logic       write, halted;
  logic [3:0] state_dbg;

  int vectors   = 0;
  int miscompares = 0;

  localparam logic [3:0] S_IDLE = 4'd0, S_FET1 = 4'd1, S_FET2 = 4'd2,
                         S_DEC  = 4'd3, S_EX1  = 4'd4, S_RD1  = 4'd5,
                         S_RD2  = 4'd6, S_WR1  = 4'd7, S_WR2  = 4'd8,
                         S_BR1  = 4'd9, S_BR2  = 4'd10, S_HALT = 4'd11;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .zero          (zero),
    .load_R0       (load_R0),
    .load_R1       (load_R1),
    .load_R2       (load_R2),
    .load_R3       (load_R3),
    .load_PC       (load_PC),
    .inc_PC        (inc_PC),
    .load_IR       (load_IR),
    .load_Add_R    (load_Add_R),
    .load_Reg_Y    (load_Reg_Y),
    .load_Reg_Z    (load_Reg_Z),
    .sel_bus_1_mux (sel_bus_1_mux),
    .sel_bus_2_mux (sel_bus_2_mux),
    .write         (write),
    .halted        (halted),
    .state_dbg     (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word builder: r = {R3,R2,R1,R0}
  function automatic logic [16:0] ev(input logic [3:0] r, input logic pc,
                                     input logic inc, input logic ir,
                                     input logic ar, input logic y,
                                     input logic z, input logic [2:0] s1,
                                     input logic [1:0] s2, input logic wr,
                                     input logic h);
    return {r, pc, inc, ir, ar, y, z, s1, s2, wr, h};
  endfunction

  function automatic logic [16:0] obs();
    return {load_R3, load_R2, load_R1, load_R0, load_PC, inc_PC, load_IR,
            load_Add_R, load_Reg_Y, load_Reg_Z, sel_bus_1_mux, sel_bus_2_mux,
            write, halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_st,
                     input logic [16:0] exp_out);
    #1;
    vectors++;
    assert (state_dbg === exp_st) else begin
      miscompares++;
      $error("FAIL %s state obs=%0d exp=%0d", tag, state_dbg, exp_st);
    end
    vectors++;
    assert (obs() === exp_out) else begin
      miscompares++;
      $error("FAIL %s outputs obs=%b exp=%b", tag, obs(), exp_out);
    end
  endtask

  // Commonly used expected words
  logic [16:0] e_none, e_fet1, e_fet2, e_addr_pc, e_mem_ar_inc;

  initial begin
    e_none       = ev(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0);
    e_fet1       = ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
    e_fet2       = ev(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
    e_addr_pc    = e_fet1;
    e_mem_ar_inc = ev(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0);

    rst = 1'b0; instruction = 8'h00; zero = 1'b0;
    #3;
    chk("reset", S_IDLE, e_none);
    tick(); tick();
    chk("reset_hold", S_IDLE, e_none);
    rst = 1'b1;

    // NOP walk from reset release
    chk("nop_idle", S_IDLE, e_none);
    tick(); chk("nop_fet1", S_FET1, e_fet1);
    tick(); chk("nop_fet2", S_FET2, e_fet2);
    tick(); chk("nop_dec",  S_DEC,  e_none);
    tick(); chk("nop_back", S_FET1, e_fet1);

    // ADD src=R1 dest=R2
    instruction = 8'h16;
    tick(); chk("add_fet2", S_FET2, e_fet2);
    tick(); chk("add_dec",  S_DEC, ev(4'b0000, 0, 0, 0, 0, 1, 0, 3'd1, 2'd1, 0, 0));
    tick(); chk("add_ex1",  S_EX1, ev(4'b0100, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
    tick(); chk("add_back", S_FET1, e_fet1);

    // SUB src=R3 dest=R0
    instruction = 8'h2C;
    tick(); chk("sub_fet2", S_FET2, e_fet2);
    tick(); chk("sub_dec",  S_DEC, ev(4'b0000, 0, 0, 0, 0, 1, 0, 3'd3, 2'd1, 0, 0));
    tick(); chk("sub_ex1",  S_EX1, ev(4'b0001, 0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 0, 0));
    tick(); chk("sub_back", S_FET1, e_fet1);

    // NOT src=R2 dest=R3
    instruction = 8'h4B;
    tick(); chk("not_fet2", S_FET2, e_fet2);
    tick(); chk("not_dec",  S_DEC, ev(4'b1000, 0, 0, 0, 0, 0, 1, 3'd2, 2'd0, 0, 0));
    tick(); chk("not_back", S_FET1, e_fet1);

    // RD dest=R3
    instruction = 8'h53;
    tick(); chk("rd_fet2", S_FET2, e_fet2);
    tick(); chk("rd_dec",  S_DEC, e_addr_pc);
    tick(); chk("rd_rd1",  S_RD1, e_mem_ar_inc);
    tick(); chk("rd_rd2",  S_RD2, ev(4'b1000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    tick(); chk("rd_back", S_FET1, e_fet1);

    // WR src=R3 dest=R2
    instruction = 8'h6E;
    tick(); chk("wr_fet2", S_FET2, e_fet2);
    tick(); chk("wr_dec",  S_DEC, e_addr_pc);
    tick(); chk("wr_wr1",  S_WR1, e_mem_ar_inc);
    tick(); chk("wr_wr2",  S_WR2, ev(4'b0000, 0, 0, 0, 0, 0, 0, 3'd3, 2'd0, 1, 0));
    tick(); chk("wr_back", S_FET1, e_fet1);

    // BRZ not taken
    instruction = 8'h80; zero = 1'b0;
    tick(); chk("brz0_fet2", S_FET2, e_fet2);
    tick(); chk("brz0_dec",  S_DEC, ev(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
    tick(); chk("brz0_back", S_FET1, e_fet1);

    // BRZ taken
    zero = 1'b1;
    tick(); chk("brz1_fet2", S_FET2, e_fet2);
    tick(); chk("brz1_dec",  S_DEC, e_addr_pc);
    tick(); chk("brz1_br1",  S_BR1, ev(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    tick(); chk("brz1_br2",  S_BR2, ev(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
    tick(); chk("brz1_back", S_FET1, e_fet1);
    zero = 1'b0;

    // Illegal opcode
    instruction = 8'hF0;
    tick(); chk("ill_fet2", S_FET2, e_fet2);
    tick(); chk("ill_dec",  S_DEC, e_none);
`ifdef RISC_ILLEGAL_NOP_EN
    tick(); chk("ill_nop_back", S_FET1, e_fet1);
    tick(); chk("ill_nop_fet2", S_FET2, e_fet2);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ill_halt", S_HALT, ev(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1));
    end
`endif
    // Asynchronous reset, asserted between edges
    rst = 1'b0;
    chk("halt_rst", S_IDLE, e_none);
    tick(); chk("halt_rst_hold", S_IDLE, e_none);

    // Reset abort during WR (src=R1 dest=R0)
    instruction = 8'h64;
    rst = 1'b1;
    chk("ab_idle", S_IDLE, e_none);
    tick(); chk("ab_fet1", S_FET1, e_fet1);
    tick(); chk("ab_fet2", S_FET2, e_fet2);
    tick(); chk("ab_dec",  S_DEC, e_addr_pc);
    tick(); chk("ab_wr1",  S_WR1, e_mem_ar_inc);
    rst = 1'b0;
    chk("ab_rst", S_IDLE, e_none);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("ab_rst_hold", S_IDLE, e_none);
    end
    instruction = 8'h00;
    rst = 1'b1;
    chk("ab_rel_idle", S_IDLE, e_none);
    tick(); chk("ab_rel_fet1", S_FET1, e_fet1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
